// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: finds the start bit, samples each bit at mid-bit
// using an Oversample-times baud tick, and reports parity/framing/break flags per word.
module uart_rx_os #(
  parameter int DataWidth  = 8,
  parameter int Oversample = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tick_i,
  input  logic                 rxd_i,
  input  logic [1:0]           parity_mode_i,
  input  logic                 two_stop_i,
  output logic                 dv_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_o,
  output logic                 busy_o
);

  localparam int TickW = $clog2(Oversample);
  localparam int BitW  = $clog2(DataWidth + 1);

  localparam logic [TickW-1:0] TickMid  = TickW'(Oversample / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(Oversample - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DataWidth - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } state_t;

  state_t               state;
  logic                 rxd_meta;
  logic                 rxd;
  logic [TickW-1:0]     tick_cnt;
  logic [BitW-1:0]      bit_cnt;
  logic [DataWidth-1:0] shift_reg;
  logic                 par_en;
  logic                 par_odd;
  logic                 two_stop;
  logic                 second_stop;
  logic                 perr_pend;
  logic                 ferr_pend;
  logic                 zero_pend;
  logic                 stop_final;
  logic                 brk_now;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxd_meta <= 1'b1;
      rxd      <= 1'b1;
    end else begin
      rxd_meta <= rxd_i;
      rxd      <= rxd_meta;
    end
  end

  // zero_pend tracks "every bit so far was 0" up to and including the first stop bit.
  assign stop_final = !two_stop || second_stop;
  assign brk_now    = zero_pend && (second_stop || !rxd);
  assign busy_o     = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_en       <= 1'b0;
      par_odd      <= 1'b0;
      two_stop     <= 1'b0;
      second_stop  <= 1'b0;
      perr_pend    <= 1'b0;
      ferr_pend    <= 1'b0;
      zero_pend    <= 1'b0;
      dv_o         <= 1'b0;
      data_o       <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      break_o      <= 1'b0;
    end else begin
      dv_o <= 1'b0;
      if (tick_i) begin
        case (state)
          IDLE: begin
            if (!rxd) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == TickMid) begin
              tick_cnt <= '0;
              if (!rxd) begin
                state       <= DATA;
                bit_cnt     <= '0;
                par_en      <= (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
                par_odd     <= (parity_mode_i == 2'b10);
                two_stop    <= two_stop_i;
                second_stop <= 1'b0;
                perr_pend   <= 1'b0;
                ferr_pend   <= 1'b0;
                zero_pend   <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TickW'(1);
            end
          end
          DATA: begin
            if (tick_cnt == TickLast) begin
              tick_cnt  <= '0;
              shift_reg <= {rxd, shift_reg[DataWidth-1:1]};
              if (rxd) zero_pend <= 1'b0;
              if (bit_cnt == BitLast) begin
                bit_cnt <= '0;
                state   <= par_en ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + BitW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TickW'(1);
            end
          end
          PARITY: begin
            if (tick_cnt == TickLast) begin
              tick_cnt  <= '0;
              perr_pend <= (^shift_reg) ^ rxd ^ par_odd;
              if (rxd) zero_pend <= 1'b0;
              state <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TickW'(1);
            end
          end
          STOP: begin
            if (tick_cnt == TickLast) begin
              tick_cnt <= '0;
              if (!stop_final) begin
                second_stop <= 1'b1;
                if (!rxd) ferr_pend <= 1'b1;
                if (rxd) zero_pend <= 1'b0;
              end else begin
                data_o       <= shift_reg;
                parity_err_o <= perr_pend;
                frame_err_o  <= ferr_pend || !rxd;
                break_o      <= brk_now;
                dv_o         <= 1'b1;
                state        <= brk_now ? BREAK_WAIT : IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TickW'(1);
            end
          end
          BREAK_WAIT: begin
            if (rxd) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Oversampling UART receiver and parametrised successor of the basic single-tick receiver. It finds the start bit and samples every bit at mid-bit using an N-times baud tick. Data width is a parameter; parity mode and stop-bit count are runtime-selectable. It reports parity, framing and break conditions alongside each received word, and sits between the pad-side rxd line and the UART register/FIFO block.

Parameters:
DataWidth, 8, data bits per frame, legal 5..9, LSB first.
Oversample, 16, tick_i pulses per bit period, even, legal 4..64.

Ports:
clk_i  input  1  system clock.
rst_i  input  1  synchronous active-high reset.
tick_i  input  1  oversample strobe, 1-cycle pulse, Oversample per bit.
rxd_i  input  1  asynchronous serial input, idles high.
parity_mode_i  input  2  00 none, 01 even, 10 odd, 11 treated as none.
two_stop_i  input  1  0 = one stop bit, 1 = two stop bits.
dv_o  output  1  1-cycle pulse: new word and flags valid.
data_o  output  DataWidth  last received word, held until next dv_o.
parity_err_o  output  1  parity mismatch on last word, valid with dv_o, held.
frame_err_o  output  1  a stop bit sampled 0 on last word, held.
break_o  output  1  last frame was a break, held.
busy_o  output  1  high whenever the FSM is not Idle.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: state Idle, counters 0, both synchroniser flops 1, data_o 0, dv_o/parity_err_o/frame_err_o/break_o/busy_o 0.
- rxd_i passes through a 2-flop synchroniser. All decisions below use the synchronised value rxd.
- The FSM and counters advance only in cycles with tick_i = 1. With no ticks, everything holds.
- Counters:
  - tick_cnt: width $clog2(Oversample), cleared on each transition.
  - bit_cnt: width $clog2(DataWidth+1).
- Idle: on a tick with rxd = 0, go to Start with tick_cnt = 0.
- Start: increment tick_cnt. At tick_cnt == Oversample/2-1 (mid start bit):
  - rxd = 0: go to Data, clear counters, latch parity_mode_i and two_stop_i into internal config.
  - rxd = 1: false start, return to Idle with no outputs.
- Config latched at Start is used for the whole frame. Port changes mid-frame are ignored.
- Data: at tick_cnt == Oversample-1, shift rxd in as MSB (LSB-first frame), clear tick_cnt, increment bit_cnt. After bit DataWidth-1 is sampled, go to Parity if parity is enabled, else Stop.
- Parity: sample at tick_cnt == Oversample-1. Error if XOR(data, parity bit) is 1 in even mode, or 0 in odd mode.
- Stop: sample at tick_cnt == Oversample-1.
  - A 0 sets the pending frame error.
  - If two_stop is latched, the second stop bit is sampled the same way.
  - On the final stop sample, go to Idle, or to BreakWait if a break was detected.
- Break: every data bit 0, parity bit 0 (if present) and first stop bit 0. Break also sets frame_err_o.
- BreakWait: stay until a tick sees rxd = 1, then go to Idle. No new start is detected while in BreakWait.
- Output update at the clock edge that processes the final stop sample:
  - data_o and all three flags are updated together.
  - dv_o is high for exactly one cycle.
- Back-to-back frames: Idle is entered at mid stop bit, so a start edge immediately after the stop bit is caught. Minimum frame spacing is 0.
- Reset mid-frame: immediate return to Idle, no dv_o, outputs return to reset values.
- tick_i held high continuously is legal and simply runs the FSM at clk rate.

Test Plan:
1. Oversample=16, 8N1, send 0xA5 -> exactly one dv_o pulse; data_o=0xA5; parity_err_o=0, frame_err_o=0, break_o=0; busy_o falls in the dv_o cycle.
2. Even parity, send 0x37 with parity bit 1 -> parity_err_o=0. Resend 0x37 with parity bit 0 -> data_o=0x37, parity_err_o=1.
3. rxd low for 4 ticks then high -> no dv_o, busy_o high for at most 8 ticks, then back to Idle. Next frame 0x12 is received correctly.
4. Send 0x55 with stop bit 0 -> dv_o, frame_err_o=1. With two_stop_i=1, first stop 1 and second stop 0 -> frame_err_o=1, data_o=0x55.
5. rxd held low for 30 bit periods -> one dv_o, data_o=0x00, break_o=1, frame_err_o=1, busy_o stays high. After rxd returns high, busy_o drops and a following frame 0xC3 is received with break_o=0.
6. Assert rst_i during data bit 4 -> all outputs 0, no dv_o. Next frame 0x3C is received correctly. Two back-to-back frames 0x01 then 0xFE give two dv_o pulses with the correct data.
